// File: rtl/ro_packer_pkg.sv
// Shared types and sizing helpers for the ring-oscillator result packer.
package ro_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } t_packer_state;

    function automatic int slots_per_line(input int cl_width, input int slot_width);
        return cl_width / slot_width;
    endfunction

    // A single channel still needs one bit to carry its index.
    function automatic int ch_bits(input int num_ch);
        return (num_ch > 32'sd1) ? $clog2(num_ch) : 32'sd1;
    endfunction

endpackage

// File: rtl/ro_result_packer_rr_arbiter.sv
// Round-robin arbiter over the sample FIFOs; the pointer restarts at channel 0 on rst or clear.
module rr_arbiter
    import ro_packer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = ch_bits(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [IDX_W-1:0]    idx_s;
    logic                found_s;
    logic [2*NUM_CH-1:0] rot_s;
    logic [SUM_W-1:0]    sum_s;
    logic [SUM_W-1:0]    sum_nxt_s;

    // Rotate requests so bit k is channel rr_ptr+k, then take the lowest set bit.
    always_comb begin
        rot_s   = {req, req} >> rr_ptr_q;
        found_s = 1'b0;
        idx_s   = '0;
        sum_s   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum_s = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                idx_s   = (sum_s >= SUM_W'(NUM_CH)) ? IDX_W'(sum_s - SUM_W'(NUM_CH))
                                                    : IDX_W'(sum_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves just past the channel that was actually popped.
    always_comb begin
        sum_nxt_s = {1'b0, idx_s} + SUM_W'(1);
        if (clear) begin
            rr_ptr_d = '0;
        end else if (advance && found_s) begin
            rr_ptr_d = (sum_nxt_s >= SUM_W'(NUM_CH)) ? '0 : IDX_W'(sum_nxt_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant     = found_s ? (NUM_CH'(1) << idx_s) : '0;
    assign grant_idx = idx_s;
    assign valid     = found_s;

endmodule

// File: rtl/ro_result_packer.sv
// Drains NUM_CH ring-oscillator sample FIFOs round-robin and packs them into cache lines.
// Build option RO_PACKER_CH_TAG_EN stores the source channel in the top bits of each slot.
module ro_result_packer
    import ro_packer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_WIDTH = 20,
    parameter int SLOT_WIDTH   = 32,
    parameter int CL_WIDTH     = 512,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           go,
    input  logic [COUNT_WIDTH-1:0]         total_lines,
    input  logic                           flush,
    input  logic [NUM_CH-1:0]              ch_empty,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_rd_data,
    output logic [NUM_CH-1:0]              ch_rd_en,
    input  logic                           wr_full,
    output logic                           wr_en,
    output logic [CL_WIDTH-1:0]            wr_data,
    output logic [COUNT_WIDTH-1:0]         lines_written,
    output logic                           busy,
    output logic                           done
);

    localparam int SLOTS   = slots_per_line(CL_WIDTH, SLOT_WIDTH);
    localparam int CH_BITS = ch_bits(NUM_CH);
    localparam int CNT_W   = $clog2(SLOTS + 1);
    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

    if ((CL_WIDTH % SLOT_WIDTH) != 32'sd0) begin : g_bad_line
        $error("CL_WIDTH must be a multiple of SLOT_WIDTH");
    end

    logic [CH_BITS-1:0]      grant_idx_s;
    logic [NUM_CH-1:0]       grant_s;
    logic                    gnt_valid_s;
    logic [SAMPLE_WIDTH-1:0] sample_s;
    logic [SLOT_WIDTH-1:0]   samp_slot_s;

`ifdef RO_PACKER_CH_TAG_EN
    if (SLOT_WIDTH < SAMPLE_WIDTH + CH_BITS) begin : g_bad_slot
        $error("SLOT_WIDTH too small for sample plus channel tag");
    end
    localparam logic [SLOT_WIDTH-1:0] PAD_SLOT = {{CH_BITS{1'b1}}, {(SLOT_WIDTH-CH_BITS){1'b0}}};
    assign samp_slot_s = SLOT_WIDTH'(sample_s) | {grant_idx_s, {(SLOT_WIDTH-CH_BITS){1'b0}}};
`else
    if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_bad_slot
        $error("SLOT_WIDTH smaller than SAMPLE_WIDTH");
    end
    localparam logic [SLOT_WIDTH-1:0] PAD_SLOT = '0;
    assign samp_slot_s = SLOT_WIDTH'(sample_s);
`endif

    t_packer_state          state_q, state_d;
    logic [CNT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [CL_WIDTH-1:0]    line_q, line_d;
    logic [COUNT_WIDTH-1:0] lines_q, lines_d;
    logic [COUNT_WIDTH-1:0] total_q, total_d;
    logic [COUNT_WIDTH:0]   lines_inc_s;
    logic [COUNT_WIDTH-1:0] lines_sat_s;
    logic [CNT_W-1:0]       wr_idx_s;
    logic                   full_s;
    logic                   rd_s;
    logic                   wr_s;
    logic                   last_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .clear     (go),
        .req       (~ch_empty),
        .advance   (rd_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .valid     (gnt_valid_s)
    );

    assign sample_s    = SAMPLE_WIDTH'(ch_rd_data >> (int'(grant_idx_s) * SAMPLE_WIDTH));
    assign lines_inc_s = {1'b0, lines_q} + (COUNT_WIDTH+1)'(1);
    assign lines_sat_s = (&lines_q) ? lines_q : lines_inc_s[COUNT_WIDTH-1:0];

    // Packing FSM: a write frees the line in the same cycle, so a concurrent read lands in slot 0.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        line_d     = line_q;
        lines_d    = lines_q;
        total_d    = total_q;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        last_s     = 1'b0;
        wr_idx_s   = slot_cnt_q;
        full_s     = (slot_cnt_q == SLOTS_C);
        if (go) begin
            total_d    = total_lines;
            slot_cnt_d = '0;
            lines_d    = '0;
            line_d     = '0;
            state_d    = (total_lines == '0) ? ST_DONE : ST_PACK;
        end else begin
            case (state_q)
                ST_PACK: begin
                    wr_s     = full_s && !wr_full;
                    last_s   = wr_s && (lines_inc_s == {1'b0, total_q});
                    rd_s     = gnt_valid_s && !flush && !last_s && (!full_s || wr_s);
                    wr_idx_s = wr_s ? '0 : slot_cnt_q;
                    if (wr_s) begin
                        slot_cnt_d = '0;
                        lines_d    = lines_sat_s;
                    end else begin
                        slot_cnt_d = slot_cnt_q;
                    end
                    if (rd_s) begin
                        for (int s = 0; s < SLOTS; s++) begin
                            line_d[s*SLOT_WIDTH +: SLOT_WIDTH] = (wr_idx_s == CNT_W'(s)) ?
                                samp_slot_s : line_q[s*SLOT_WIDTH +: SLOT_WIDTH];
                        end
                        slot_cnt_d = wr_idx_s + CNT_W'(1);
                    end else begin
                        line_d = line_q;
                    end
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else if (flush) begin
                        state_d = (slot_cnt_d == '0) ? ST_DONE : ST_PAD;
                    end else begin
                        state_d = ST_PACK;
                    end
                end
                ST_PAD: begin
                    if (full_s) begin
                        wr_s = !wr_full;
                        if (wr_s) begin
                            slot_cnt_d = '0;
                            lines_d    = lines_sat_s;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end else begin
                        for (int s = 0; s < SLOTS; s++) begin
                            line_d[s*SLOT_WIDTH +: SLOT_WIDTH] = (CNT_W'(s) >= slot_cnt_q) ?
                                PAD_SLOT : line_q[s*SLOT_WIDTH +: SLOT_WIDTH];
                        end
                        slot_cnt_d = SLOTS_C;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, line buffer and counters; rst discards any partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            line_q     <= '0;
            lines_q    <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            line_q     <= line_d;
            lines_q    <= lines_d;
            total_q    <= total_d;
        end
    end

    assign ch_rd_en      = rd_s ? grant_s : '0;
    assign wr_en         = wr_s;
    assign wr_data       = line_q;
    assign lines_written = lines_q;
    assign busy          = (state_q == ST_PACK) || (state_q == ST_PAD);
    assign done          = (state_q == ST_DONE);

endmodule

// File: doc/ro_result_packer.md
Name: ro_result_packer

Overview:
- Multi-channel successor to the single-FIFO sample packer in the ring-oscillator AFU.
- Drains NUM_CH ring-oscillator sample FIFOs with round-robin arbitration.
- Packs samples into cache-line slots and presents full lines to the DMA write channel.
- Adds a line budget, an explicit flush of a partial tail line, and a done indication.

Parameters:
- NUM_CH, 4, number of sample FIFO channels (1..16).
- SAMPLE_WIDTH, 20, width of each FIFO sample.
- SLOT_WIDTH, 32, width of one result slot in a line; must be >= SAMPLE_WIDTH (+ CH_BITS with tag).
- CL_WIDTH, 512, cache-line width; SLOTS = CL_WIDTH/SLOT_WIDTH (must divide exactly).
- COUNT_WIDTH, 32, width of line counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  start pulse; clears state and begins packing.
- total_lines  in  COUNT_WIDTH  lines to write before done; sampled on go.
- flush  in  1  pulse; finish the partial line with padding, then done.
- ch_empty  in  NUM_CH  per-channel FIFO empty (show-ahead FIFOs).
- ch_rd_data  in  NUM_CH*SAMPLE_WIDTH  channel c occupies bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- ch_rd_en  out  NUM_CH  one-hot pop; at most one bit set per cycle.
- wr_full  in  1  DMA write buffer full.
- wr_en  out  1  write wr_data this cycle.
- wr_data  out  CL_WIDTH  packed line; slot 0 in the LSBs holds the oldest sample.
- lines_written  out  COUNT_WIDTH  lines accepted since go.
- busy  out  1  high in PACK/PAD.
- done  out  1  sticky until next go or rst.

Behaviour:
- Reset values: ch_rd_en=0, wr_en=0, wr_data=0, lines_written=0, busy=0, done=0. Internal: slot_cnt=0, rr_ptr=0, state IDLE.
- FSM states: IDLE, PACK, PAD, DONE.
- IDLE -> PACK on go. IDLE -> DONE on go if total_lines==0; done is high the cycle after go.
- go in any state restarts: slot_cnt, lines_written, rr_ptr and done are cleared, and total_lines is re-latched.
- Arbitration in PACK: grant the first non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
  - After a grant to channel c, rr_ptr = (c+1) mod NUM_CH.
  - No grant if all channels are empty.
- A read occurs when a grant exists and the line is not full. A line is full when slot_cnt==SLOTS and it was not written this cycle.
- On a read, the zero-extended sample is written to slot[slot_cnt] and slot_cnt increments.
- wr_en = (slot_cnt==SLOTS) && !wr_full, combinational.
- On wr_en: slot_cnt resets and lines_written increments. A read in the same cycle lands in slot 0 of the next line (zero-bubble). wr_data is stable while wr_en is waiting on wr_full.
- Unused upper bits of each slot are 0.
- The last budgeted line is written when lines_written+1 == total_lines. That write -> DONE; no reads in the same or later cycles.
- flush in PACK:
  - Stop granting immediately.
  - If slot_cnt==0 -> DONE next cycle.
  - Otherwise -> PAD: fill remaining slots with zero in one cycle (slot_cnt=SLOTS), then wr_en under normal wr_full rules, then -> DONE.
- flush in IDLE, PAD or DONE is ignored.
- flush and go in the same cycle: go wins.
- DONE: ch_rd_en=0, wr_en=0, done=1.
- rst mid-operation: everything returns to its reset value immediately; a partial line is discarded.
- lines_written saturates at all-ones; it never wraps.

Optional Feature:
- Macro: RO_PACKER_CH_TAG_EN.
- Defined:
  - CH_BITS = max(1, $clog2(NUM_CH)).
  - Each slot's top CH_BITS bits carry the source channel index; padded slots carry all-ones tag.
  - Elaboration error if SLOT_WIDTH < SAMPLE_WIDTH + CH_BITS.
- Undefined: tag bits are zero, matching the untagged layout.

Decomposition:
- Package ro_packer_pkg:
  - State enum t_packer_state.
  - Function slots_per_line(CL_WIDTH, SLOT_WIDTH).
  - Function ch_bits(NUM_CH).
- Sub-module rr_arbiter (NUM_CH): inputs req vector, advance strobe; outputs one-hot grant, grant index, valid. Owns rr_ptr and is reset by rst and go.

Test Plan:
- NUM_CH=4; only ch2 non-empty; total_lines=1; ch2 supplies samples 0..15 -> one wr_en, slots 0..15 = 0..15, done next cycle, lines_written=1.
- All four channels always non-empty; 32 reads -> grant sequence 0,1,2,3,0,...; slot k holds a sample from channel k mod 4; with tag enabled, top 2 bits of slot k = k mod 4.
- wr_full held high 5 cycles with a full line -> wr_data stable, ch_rd_en=0 throughout; on release, wr_en for 1 cycle and the concurrent read lands in slot 0.
- 5 samples then flush -> PAD, slots 5..15 = 0 (tag all-ones if enabled), single wr_en, done; no further ch_rd_en.
- go with total_lines=0 -> done next cycle, no ch_rd_en or wr_en.
- rst asserted mid-line at slot_cnt=7, then go with total_lines=2 -> outputs at reset values during rst; 32 fresh samples give 2 lines with no stale data, then done.
